// File: rtl/ysyx_25030081_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Latency: none (declarations only).
// Backpressure: n/a.
package ysyx_25030081_pkg;

    // One-hot state encoding, so every handshake output is a single state bit.
    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        REQ  = 4'b0010,
        WAIT = 4'b0100,
        HOLD = 4'b1000
    } ifu_state_t;

    localparam logic [31:0] RESET_VEC_DEFAULT = 32'h8000_0000;

    // addi x0, x0, 0. Decode can use it as a bubble.
    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/ysyx_25030081_pc_reg.sv
// Architectural PC register with write enable and async reset to RESET_VEC.
// Latency: d appears on q one clock after a cycle with we=1.
// Backpressure: none; q holds its value whenever we is low.
module ysyx_25030081_pc_reg
    import ysyx_25030081_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VEC  = RESET_VEC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    // Load on write enable; reset forces the boot vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VEC;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ysyx_25030081_ifu.sv
// Instruction fetch: issues one imem read per PC and hands the word plus PC to decode.
// Latency: at least 3 cycles per instruction (request, response, hold).
// Backpressure: the request is held until imem_req_ready; the instruction is held until inst_ready.
// Build option YSYX_25030081_IFU_MISALIGN_CHK_EN: a misaligned next_pc skips the fetch and
// delivers a faulted instruction with inst_misalign set. Without it, the two low bits of
// next_pc are cleared.
module ysyx_25030081_ifu
    import ysyx_25030081_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VEC  = RESET_VEC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_resp_valid,
    output logic                  imem_resp_ready,
    input  logic [DATA_WIDTH-1:0] imem_resp_data,
    input  logic                  imem_resp_err,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst,
    output logic                  inst_fault,
`ifdef YSYX_25030081_IFU_MISALIGN_CHK_EN
    output logic                  inst_misalign,
`endif
    output logic [DATA_WIDTH-1:0] pc,
    input  logic [DATA_WIDTH-1:0] next_pc
);

    ifu_state_t            state_q;
    ifu_state_t            state_d;
    logic                  pc_we;
    logic                  inst_we;
    logic [DATA_WIDTH-1:0] pc_d;
`ifdef YSYX_25030081_IFU_MISALIGN_CHK_EN
    logic                  misalign_take;
    logic                  misalign_q;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and the load strobes for pc and inst.
    always_comb begin
        state_d = state_q;
        pc_we   = 1'b0;
        inst_we = 1'b0;
`ifdef YSYX_25030081_IFU_MISALIGN_CHK_EN
        misalign_take = 1'b0;
`endif
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    inst_we = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (inst_ready) begin
                    pc_we = 1'b1;
`ifdef YSYX_25030081_IFU_MISALIGN_CHK_EN
                    // A misaligned target never reaches memory. The fault is
                    // presented straight away as a new instruction.
                    if (next_pc[1:0] != 2'b00) begin
                        misalign_take = 1'b1;
                        state_d       = HOLD;
                    end else begin
                        state_d = REQ;
                    end
`else
                    state_d = REQ;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef YSYX_25030081_IFU_MISALIGN_CHK_EN
    assign pc_d = next_pc;
`else
    // Instructions are word aligned. The two low bits are dropped, not trapped.
    assign pc_d = next_pc & ~{{(DATA_WIDTH-2){1'b0}}, 2'b11};
`endif

    // Each handshake output is one state bit, so it cannot glitch.
    assign imem_req_valid  = (state_q == REQ);
    assign imem_resp_ready = (state_q == WAIT);
    assign inst_valid      = (state_q == HOLD);
    assign imem_req_addr   = pc;

    // Capture the fetched word and its fault flag. They stay stable through HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst       <= '0;
            inst_fault <= 1'b0;
        end else if (inst_we) begin
            inst       <= imem_resp_data;
            inst_fault <= imem_resp_err;
`ifdef YSYX_25030081_IFU_MISALIGN_CHK_EN
        end else if (misalign_take) begin
            inst       <= '0;
            inst_fault <= 1'b1;
`endif
        end
    end

`ifdef YSYX_25030081_IFU_MISALIGN_CHK_EN
    // The misalign flag is updated on every decode handshake. It is set only
    // when the accepted target was misaligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if (pc_we) begin
            misalign_q <= misalign_take;
        end
    end

    assign inst_misalign = misalign_q;
`endif

    ysyx_25030081_pc_reg #(
        .DATA_WIDTH(DATA_WIDTH),
        .RESET_VEC (RESET_VEC)
    ) u_pc_reg (
        .clk(clk),
        .rst(rst),
        .we (pc_we),
        .d  (pc_d),
        .q  (pc)
    );

endmodule

// File: tb/tb_ysyx_25030081_ifu.sv
// Directed and randomized bench for the fetch unit. It drives the bus in lock-step and
// keeps a scoreboard of the expected architectural PC and the last delivered word.
module tb_ysyx_25030081_ifu;

    localparam logic [31:0] RV = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic        imem_resp_ready;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic        inst_fault;
`ifdef YSYX_25030081_IFU_MISALIGN_CHK_EN
    logic        inst_misalign;
`endif
    logic [31:0] pc;
    logic [31:0] next_pc;

    int          compared   = 0;
    int          mismatched = 0;
    int          req_cnt    = 0;
    logic [31:0] exp_pc;
    logic [31:0] last_data;
    logic        last_err;

    ysyx_25030081_ifu dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_ready(imem_resp_ready),
        .imem_resp_data (imem_resp_data),
        .imem_resp_err  (imem_resp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_fault     (inst_fault),
`ifdef YSYX_25030081_IFU_MISALIGN_CHK_EN
        .inst_misalign  (inst_misalign),
`endif
        .pc             (pc),
        .next_pc        (next_pc)
    );

    always #5 clk = ~clk;

    // Count accepted fetch requests independently of the bench's stimulus bookkeeping.
    always @(posedge clk) begin
        if (imem_req_valid === 1'b1 && imem_req_ready === 1'b1) req_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run one fetch from REQ to HOLD. An early response may be driven in the accept cycle;
    // it must be ignored.
    task automatic do_fetch(input int req_stall, input int resp_delay,
                            input logic [31:0] data, input logic err, input logic early);
        int base;
        base = req_cnt;
        chk1("req_valid", imem_req_valid, 1'b1);
        chk ("req_addr", imem_req_addr, exp_pc);
        chk1("resp_ready_in_req", imem_resp_ready, 1'b0);
        for (int i = 0; i < req_stall; i++) begin
            imem_req_ready = 1'b0;
            step();
            chk1("req_hold_valid", imem_req_valid, 1'b1);
            chk ("req_hold_addr", imem_req_addr, exp_pc);
        end
        imem_req_ready = 1'b1;
        if (early) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = ~data;
            imem_resp_err   = ~err;
        end
        step();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        chk("req_count", req_cnt - base, 32'd1);
        for (int i = 0; i < resp_delay; i++) begin
            chk1("wait_resp_ready", imem_resp_ready, 1'b1);
            chk1("wait_inst_valid", inst_valid, 1'b0);
            step();
        end
        chk1("wait_resp_ready", imem_resp_ready, 1'b1);
        imem_resp_valid = 1'b1;
        imem_resp_data  = data;
        imem_resp_err   = err;
        step();
        imem_resp_valid = 1'b0;
        imem_resp_data  = $urandom;
        imem_resp_err   = 1'b0;
        last_data = data;
        last_err  = err;
        chk1("hold_inst_valid", inst_valid, 1'b1);
        chk ("hold_inst", inst, data);
        chk1("hold_inst_fault", inst_fault, err);
        chk ("hold_pc", pc, exp_pc);
        chk1("hold_req_valid", imem_req_valid, 1'b0);
        chk1("hold_resp_ready", imem_resp_ready, 1'b0);
        chk ("fetch_req_count", req_cnt - base, 32'd1);
    endtask

    // Stall decode in HOLD while next_pc wanders, then accept npc.
    task automatic do_accept(input int stall, input logic [31:0] npc);
        for (int i = 0; i < stall; i++) begin
            inst_ready = 1'b0;
            next_pc    = $urandom;
            step();
            chk1("stall_inst_valid", inst_valid, 1'b1);
            chk ("stall_inst", inst, last_data);
            chk1("stall_fault", inst_fault, last_err);
            chk ("stall_pc", pc, exp_pc);
            chk1("stall_req_valid", imem_req_valid, 1'b0);
        end
        inst_ready = 1'b1;
        next_pc    = npc;
        step();
        inst_ready = 1'b0;
        next_pc    = $urandom;
        exp_pc     = {npc[31:2], 2'b00};
        chk ("accept_pc", pc, exp_pc);
        chk1("accept_inst_valid", inst_valid, 1'b0);
        chk1("accept_req_valid", imem_req_valid, 1'b1);
        chk ("accept_req_addr", imem_req_addr, exp_pc);
    endtask

    initial begin
        logic [31:0] npc;
        logic [31:0] d;
        rst             = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        imem_resp_err   = 1'b0;
        inst_ready      = 1'b0;
        next_pc         = 32'h0;
        last_data       = 32'h0;
        last_err        = 1'b0;
        step();
        step();
        chk ("rst_pc", pc, RV);
        chk ("rst_inst", inst, 32'h0);
        chk1("rst_fault", inst_fault, 1'b0);
        chk1("rst_req_valid", imem_req_valid, 1'b0);
        chk1("rst_resp_ready", imem_resp_ready, 1'b0);
        chk1("rst_inst_valid", inst_valid, 1'b0);

        // After release the FSM is in IDLE for one cycle, then the first request appears.
        rst = 1'b0;
        chk1("idle_req_valid", imem_req_valid, 1'b0);
        step();
        exp_pc = RV;

        do_fetch(0, 1, 32'h0000_0093, 1'b0, 1'b0);
        do_accept(0, 32'h8000_0010);
        do_fetch(5, 0, 32'h1234_5678, 1'b0, 1'b1);
        do_accept(4, 32'h8000_0020);
        do_fetch(2, 3, 32'hDEAD_BEEF, 1'b1, 1'b0);
        do_accept(1, exp_pc);
        do_fetch(0, 0, 32'h0000_006F, 1'b0, 1'b0);
        do_accept(0, 32'hFFFF_FFFC);
        do_fetch(1, 1, 32'hCAFE_F00D, 1'b0, 1'b0);

`ifdef YSYX_25030081_IFU_MISALIGN_CHK_EN
        begin
            int base;
            base       = req_cnt;
            inst_ready = 1'b1;
            next_pc    = 32'h8000_0002;
            step();
            inst_ready = 1'b0;
            exp_pc     = 32'h8000_0002;
            chk1("mis_flag", inst_misalign, 1'b1);
            chk1("mis_inst_valid", inst_valid, 1'b1);
            chk1("mis_req_valid", imem_req_valid, 1'b0);
            chk ("mis_inst", inst, 32'h0);
            chk1("mis_fault", inst_fault, 1'b1);
            chk ("mis_pc", pc, exp_pc);
            step();
            chk1("mis_no_req", imem_req_valid, 1'b0);
            chk ("mis_req_count", req_cnt - base, 32'd0);
            last_data = 32'h0;
            last_err  = 1'b1;
            do_accept(0, 32'h8000_0100);
            chk1("mis_clear", inst_misalign, 1'b0);
        end
`else
        do_accept(0, 32'h8000_0102);
        chk("align_force_pc", pc, 32'h8000_0100);
`endif

        // Reset during WAIT: outputs return to reset values at once, without a clock edge.
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        chk1("pre_rst_wait", imem_resp_ready, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk ("midrst_pc", pc, RV);
        chk1("midrst_req_valid", imem_req_valid, 1'b0);
        chk1("midrst_resp_ready", imem_resp_ready, 1'b0);
        chk1("midrst_inst_valid", inst_valid, 1'b0);
        chk ("midrst_inst", inst, 32'h0);
        chk1("midrst_fault", inst_fault, 1'b0);
        step();
        rst = 1'b0;
        chk1("rerst_idle", imem_req_valid, 1'b0);
        step();
        exp_pc = RV;
        do_fetch(0, 0, 32'h0000_0013, 1'b0, 1'b0);
        do_accept(0, 32'h8000_0004);

        // Randomized traffic: the scoreboard tracks the expected PC and the word each fetch returns.
        for (int n = 0; n < 40; n++) begin
            d = $urandom;
            do_fetch($urandom_range(0, 3), $urandom_range(0, 3), d,
                     ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1);
            case ($urandom_range(0, 4))
                0:       npc = exp_pc;
                1:       npc = 32'hFFFF_FFFC;
                2:       npc = exp_pc + 32'd4;
                default: npc = $urandom;
            endcase
`ifdef YSYX_25030081_IFU_MISALIGN_CHK_EN
            npc[1:0] = 2'b00;
`endif
            do_accept($urandom_range(0, 2), npc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ysyx_25030081_ifu.md
Name: ysyx_25030081_ifu

Overview:
- Instruction fetch unit: holds the architectural PC, issues instruction-memory reads over a valid/ready request/response channel, and presents the fetched instruction plus its PC to decode.
- Its pc output feeds the next-PC stage. That stage's next_pc result is latched here when decode accepts the current instruction.
- Multicycle core: one instruction in flight, no speculation.

Parameters:
- DATA_WIDTH, 32, width of PC, address and instruction.
- RESET_VEC, 32'h8000_0000, PC value after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  DATA_WIDTH  fetch address (equals pc).
- imem_resp_valid  in  1  response data valid.
- imem_resp_ready  out  1  IFU accepts response.
- imem_resp_data  in  DATA_WIDTH  fetched instruction word.
- imem_resp_err  in  1  access fault on this response.
- inst_valid  out  1  inst/pc valid to decode.
- inst_ready  in  1  decode/execute consumed instruction; next_pc final this cycle.
- inst  out  DATA_WIDTH  registered instruction.
- inst_fault  out  1  instruction carries fetch fault.
- pc  out  DATA_WIDTH  current PC, to next-PC stage and decode.
- next_pc  in  DATA_WIDTH  computed next PC from next-PC stage.

Behaviour:
- Reset: one clock (clk); reset rst is asynchronous and active-high.
  - On rst: state=IDLE, pc=RESET_VEC, inst=0, inst_fault=0.
  - All valid/ready outputs are 0 while in IDLE.
- FSM states: IDLE, REQ, WAIT, HOLD.
  - IDLE -> REQ unconditionally on the next edge. The first request is visible 1 cycle after rst deasserts.
  - REQ: imem_req_valid=1, imem_req_addr=pc, held stable until imem_req_ready. On valid&ready -> WAIT.
  - WAIT: imem_resp_ready=1. On imem_resp_valid: inst<=imem_resp_data, inst_fault<=imem_resp_err, -> HOLD. A response arriving in the same cycle the request is accepted is not accepted (ready low in REQ).
  - HOLD: inst_valid=1; inst, inst_fault and pc are held stable. On inst_ready: pc<=next_pc, -> REQ.
- Latency: request handshake at cycle t, response at t+k (k>=1), inst_valid rises at t+k+1. Minimum 3 cycles per instruction.
- imem_req_valid, imem_resp_ready and inst_valid are decoded from state (glitch-free, one-hot compare). inst, inst_fault and pc are registers.
- pc changes only on a HOLD&inst_ready handshake or on reset. next_pc is ignored at all other times.
- next_pc == pc (self-loop, e.g. jal x0,0) is legal: the same address is refetched.
- Wrap-around: next_pc=32'hFFFF_FFFC is fetched normally. No overflow handling; arithmetic belongs to the next-PC stage.
- Faulted fetch: inst_fault=1 and inst=raw data. It is still handed over with inst_valid; the consumer decides the trap.
- Reset mid-operation (in REQ/WAIT/HOLD): immediate return to IDLE. Any outstanding memory response is the memory's responsibility to drop on the same rst.
- Only one request is ever outstanding.

Optional Feature:
- Macro: YSYX_25030081_IFU_MISALIGN_CHK_EN.
- Defined:
  - On HOLD&inst_ready with next_pc[1:0]!=0: pc<=next_pc, state -> HOLD directly (no memory request).
  - inst=0, inst_fault=1, plus extra output inst_misalign=1.
  - inst_misalign clears on the next accepted handshake.
- Undefined: next_pc[1:0] is forced to 2'b00 when latched into pc. There is no inst_misalign port.

Decomposition:
- Package ysyx_25030081_pkg:
  - ifu_state_t enum {IDLE, REQ, WAIT, HOLD}.
  - RESET_VEC_DEFAULT.
  - NOP constant 32'h0000_0013 (available to decode).
- Sub-module: ysyx_25030081_pc_reg, a DATA_WIDTH register with async reset to RESET_VEC and write enable.
- FSM and datapath live in the IFU top.

Test Plan:
- Reset release, imem_req_ready=1, response 2 cycles later with data 32'h0000_0093 -> imem_req_addr=0x8000_0000; inst_valid at t+3 with inst=0x0000_0093, pc=0x8000_0000.
- HOLD with inst_ready=1, next_pc=0x8000_0010 -> next cycle pc=0x8000_0010, imem_req_valid=1, addr 0x8000_0010.
- imem_req_ready low 5 cycles -> imem_req_valid stays 1, addr unchanged; exactly one request accepted.
- inst_ready low 4 cycles in HOLD, next_pc toggling -> inst/pc stable; pc updates only on the accept cycle.
- Response with imem_resp_err=1, data 0xDEAD_BEEF -> inst_fault=1, inst=0xDEAD_BEEF, inst_valid=1.
- rst asserted in WAIT -> outputs immediately reset (pc=0x8000_0000, valids 0); fetch restarts from RESET_VEC. With the macro defined: next_pc=0x8000_0002 -> inst_misalign=1, no memory request.
